vc_pop_scheduler: RTL
=====================

// Module: vc_pop_scheduler
// PURPOSE
//  Central pop sequencer for the PCIE transaction path. It issues the Main FIFO pop toward
//  the VC demux and arbitrates VC0/VC1 pops into the VC mux. VC0 has strict priority, with
//  an anti-starvation counter for VC1. It honours VC and D0/D1 back-pressure and never pops
//  an empty FIFO. It sits between the FIFO status flags and the FIFO pop inputs, and is gated
//  by the control FSM's active state.
// PARAMETERS
//  STARVE_MAX   4  consecutive VC0 grants allowed while VC1 is non-empty before VC1 is forced (1..15)
//  BACKOFF_CYC  2  minimum cycles spent in BACKOFF after any downstream pause (1..7)
// PORTS
//  clk            in   1  single clock, all logic on posedge
//  reset          in   1  synchronous, active-high
//  enable         in   1  from control FSM (active_out); 0 = no pops issued
//  mf_empty       in   1  Main FIFO empty
//  mf_almost_empty in  1  Main FIFO holds <=1 entry
//  vc0_pause      in   1  VC0 FIFO at/above threshold
//  vc1_pause      in   1  VC1 FIFO at/above threshold
//  vc0_empty      in   1  VC0 FIFO empty
//  vc0_almost_empty in 1  VC0 FIFO holds <=1 entry
//  vc1_empty      in   1  VC1 FIFO empty
//  vc1_almost_empty in 1  VC1 FIFO holds <=1 entry
//  d0_pause       in   1  D0 FIFO at/above threshold
//  d1_pause       in   1  D1 FIFO at/above threshold
//  mf_pop         out  1  pop Main FIFO (registered)
//  vc0_pop        out  1  pop VC0 FIFO (registered)
//  vc1_pop        out  1  pop VC1 FIFO (registered)
//  state          out  2  current FSM state (debug/status)
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high. Reset clears all
//    outputs to 0, state to IDLE, starve_cnt and backoff_cnt to 0. Reset wins over every
//    other input, including mid-burst.
//  - All pops are registered: the decision made from flags sampled at edge N is visible after
//    edge N+1. Exactly 1-cycle latency.
//  - Main FIFO pop: mf_pop_next = enable & !mf_empty & !vc0_pause & !vc1_pause. Both pauses
//    are checked because the destination VC is unknown until the word is read.
//    Back-to-back rule: if mf_pop is 1 this cycle, also require !mf_almost_empty.
//  - VC pops (egress) happen only in state RUN. D0/D1 destination is unknown, so both
//    d0_pause and d1_pause must be 0.
//    - At most one of vc0_pop/vc1_pop is asserted per cycle (the mux takes one word).
//    - Eligibility: vcX_elig = !vcX_empty & !(vcX_pop & vcX_almost_empty). The second term
//      is the back-to-back guard against popping an empty FIFO.
//    - Grant: VC0 if vc0_elig and (starve_cnt < STARVE_MAX or !vc1_elig); else VC1 if
//      vc1_elig; else none.
//    - starve_cnt: +1 on a VC0 grant while vc1 is non-empty, saturating at STARVE_MAX.
//      Cleared on a VC1 grant or when vc1_empty. 4-bit width.
//  - FSM (2-bit):
//    - IDLE -> RUN when enable=1.
//    - RUN -> BACKOFF when d0_pause|d1_pause; backoff_cnt loads BACKOFF_CYC-1.
//    - BACKOFF: no VC pops; backoff_cnt decrements. -> RUN when backoff_cnt=0 and both pauses
//      are 0. Otherwise stay, with the counter held at 0.
//    - Any state -> IDLE when enable=0. In IDLE all pops are 0 next cycle and starve_cnt
//      is held, not cleared.
//    - Encoding 3 is unused; treat it as IDLE.
//  - The Main FIFO pop is independent of the FSM egress state. It needs only enable, not RUN.
//  - Simultaneous events: enable drop beats pause. A pause rising in the same cycle as a
//    grant cancels that grant.
// STRUCTURE
//  - Shared package pcie_trans_pkg: state encodings ST_IDLE=0, ST_RUN=1, ST_BACKOFF=2;
//    VC id constants VC0=0, VC1=1.
//  - One sub-module vc_arbiter: combinational grant plus registered starve_cnt, parameter
//    STARVE_MAX.
//  - The FSM, backoff counter and Main FIFO pop logic stay in the top module.
// TESTING
//  1. Reset with all FIFOs non-empty and enable=1 -> all pops 0 and state=IDLE during reset;
//     first vc0_pop appears 2 edges after reset release.
//  2. VC0 and VC1 both holding 8 entries, no pauses, STARVE_MAX=4 -> grant pattern
//     VC0,VC0,VC0,VC0,VC1 repeating; never both pops in one cycle.
//  3. VC0 holds 1 entry (almost_empty=1, empty=0) -> exactly one vc0_pop pulse, then 0;
//     VC0 never popped while empty.
//  4. d1_pause pulses high for 1 cycle in RUN with BACKOFF_CYC=2 -> state=BACKOFF, no VC
//     pops for >=2 cycles, then RUN resumes.
//  5. Main FIFO holds 3 entries with vc1_pause=1 -> mf_pop stays 0. Drop vc1_pause ->
//     3 mf_pop pulses, with a gap inserted once mf_almost_empty=1.
//  6. enable drops mid-burst -> all pops 0 from the next edge and state=IDLE. Re-enable ->
//     burst resumes with starve_cnt preserved.

Source files
------------

// File: rtl/pcie_trans_pkg.sv
// Shared definitions for the PCIE transaction path: pop-scheduler FSM states and VC identifiers.
package pcie_trans_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

endpackage

// File: rtl/vc_arbiter.sv
// VC0/VC1 egress arbiter: strict VC0 priority with a saturating anti-starvation counter for VC1.
module vc_arbiter
    import pcie_trans_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
    input  logic vc0_empty,
    input  logic vc0_almost_empty,
    input  logic vc1_empty,
    input  logic vc1_almost_empty,
    input  logic vc0_pop,
    input  logic vc1_pop,
    output logic gnt_valid,
    output logic gnt_vc
);

    logic [3:0] starve_cnt;
    logic       vc0_elig;
    logic       vc1_elig;

    // A pop already in flight on an almost-empty FIFO will drain it, so that FIFO sits out a cycle.
    always_comb begin
        vc0_elig  = !vc0_empty && !(vc0_pop && vc0_almost_empty);
        vc1_elig  = !vc1_empty && !(vc1_pop && vc1_almost_empty);
        gnt_valid = 1'b0;
        gnt_vc    = VC0;
        if (grant_en) begin
            if (vc0_elig && ((starve_cnt < 4'(STARVE_MAX)) || !vc1_elig)) begin
                gnt_valid = 1'b1;
                gnt_vc    = VC0;
            end else if (vc1_elig) begin
                gnt_valid = 1'b1;
                gnt_vc    = VC1;
            end
        end
    end

    // Counter is frozen whenever egress is not running, so a re-enabled burst keeps its history.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_en) begin
            if (vc1_empty || (gnt_valid && gnt_vc == VC1)) begin
                starve_cnt <= '0;
            end else if (gnt_valid && gnt_vc == VC0 && starve_cnt < 4'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/vc_pop_scheduler.sv
// Central pop sequencer: Main FIFO pop toward the VC demux and arbitrated VC0/VC1 pops into the VC mux.
module vc_pop_scheduler
    import pcie_trans_pkg::*;
#(
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned BACKOFF_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mf_empty,
    input  logic       mf_almost_empty,
    input  logic       vc0_pause,
    input  logic       vc1_pause,
    input  logic       vc0_empty,
    input  logic       vc0_almost_empty,
    input  logic       vc1_empty,
    input  logic       vc1_almost_empty,
    input  logic       d0_pause,
    input  logic       d1_pause,
    output logic       mf_pop,
    output logic       vc0_pop,
    output logic       vc1_pop,
    output logic [1:0] state
);

    state_t     cur_state;
    state_t     nxt_state;
    logic [2:0] backoff_cnt;
    logic [2:0] backoff_nxt;
    logic       any_pause;
    logic       grant_en;
    logic       gnt_valid;
    logic       gnt_vc;
    logic       mf_pop_next;
    logic       vc0_pop_next;
    logic       vc1_pop_next;

    assign any_pause = d0_pause | d1_pause;
    assign state     = cur_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= ST_IDLE;
            backoff_cnt <= '0;
        end else begin
            cur_state   <= nxt_state;
            backoff_cnt <= backoff_nxt;
        end
    end

    always_comb begin
        nxt_state   = ST_IDLE;
        backoff_nxt = backoff_cnt;
        if (enable) begin
            case (cur_state)
                ST_RUN: begin
                    if (any_pause) begin
                        nxt_state   = ST_BACKOFF;
                        backoff_nxt = 3'(BACKOFF_CYC - 1);
                    end else begin
                        nxt_state = ST_RUN;
                    end
                end
                ST_BACKOFF: begin
                    if (backoff_cnt == '0 && !any_pause) begin
                        nxt_state = ST_RUN;
                    end else begin
                        nxt_state = ST_BACKOFF;
                        if (backoff_cnt != '0) begin
                            backoff_nxt = backoff_cnt - 3'd1;
                        end
                    end
                end
                default: nxt_state = ST_RUN;
            endcase
        end
    end

    // A pause seen in the grant cycle suppresses the grant rather than waiting for BACKOFF.
    always_comb begin
        grant_en     = enable && (cur_state == ST_RUN) && !any_pause;
        mf_pop_next  = enable && !mf_empty && !vc0_pause && !vc1_pause
                       && !(mf_pop && mf_almost_empty);
        vc0_pop_next = gnt_valid && (gnt_vc == VC0);
        vc1_pop_next = gnt_valid && (gnt_vc == VC1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mf_pop  <= 1'b0;
            vc0_pop <= 1'b0;
            vc1_pop <= 1'b0;
        end else begin
            mf_pop  <= mf_pop_next;
            vc0_pop <= vc0_pop_next;
            vc1_pop <= vc1_pop_next;
        end
    end

    vc_arbiter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_vc_arbiter (
        .clk              (clk),
        .reset            (reset),
        .grant_en         (grant_en),
        .vc0_empty        (vc0_empty),
        .vc0_almost_empty (vc0_almost_empty),
        .vc1_empty        (vc1_empty),
        .vc1_almost_empty (vc1_almost_empty),
        .vc0_pop          (vc0_pop),
        .vc1_pop          (vc1_pop),
        .gnt_valid        (gnt_valid),
        .gnt_vc           (gnt_vc)
    );

endmodule
